// File: rtl/spi_rx_if.sv
// Byte stream from the SPI receiver to its consumer: head-of-FIFO byte, its dc tag,
// and a valid/ready handshake.
interface spi_rx_if;
    logic [7:0] rx_data;
    logic       rx_dc;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_dc,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_dc,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/spi_rx.sv
// SPI mode-0 target receiver: oversamples spi_clk/mosi/cs_n/dc in the clk domain,
// assembles MSB-first bytes tagged with dc and queues them in a small FIFO.
module spi_rx #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      spi_clk,
    input  logic      mosi,
    input  logic      cs_n,
    input  logic      dc,
    spi_rx_if.master  rx,
    output logic      overflow,
    output logic      frame_err,
    input  logic      clr_err,
    output logic      busy
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    // ---------------------------------------------------------------
    // Input synchronizers
    // ---------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_reg;
    logic [SYNC_STAGES-1:0] mosi_sync_reg;
    logic [SYNC_STAGES-1:0] csn_sync_reg;
    logic [SYNC_STAGES-1:0] dc_sync_reg;
    logic                   sclk_prev_reg;

    logic sclk_s;
    logic mosi_s;
    logic csn_s;
    logic dc_s;
    logic rise;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_reg <= '0;
            mosi_sync_reg <= '0;
            csn_sync_reg  <= '1;
            dc_sync_reg   <= '0;
            sclk_prev_reg <= 1'b0;
        end else begin
            sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], spi_clk};
            mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], mosi};
            csn_sync_reg  <= {csn_sync_reg[SYNC_STAGES-2:0], cs_n};
            dc_sync_reg   <= {dc_sync_reg[SYNC_STAGES-2:0], dc};
            sclk_prev_reg <= sclk_s;
        end
    end

    assign sclk_s = sclk_sync_reg[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_reg[SYNC_STAGES-1];
    assign csn_s  = csn_sync_reg[SYNC_STAGES-1];
    assign dc_s   = dc_sync_reg[SYNC_STAGES-1];
    assign rise   = sclk_s & ~sclk_prev_reg;
    assign busy   = ~csn_s;

    // ---------------------------------------------------------------
    // Frame FSM
    // ---------------------------------------------------------------
    state_t state_reg;
    state_t state_next;
    logic   shift_en;
    logic   abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:  if (!csn_s) state_next = ST_SHIFT;
            ST_SHIFT: if (csn_s)  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Deselect takes priority over a coincident rise so a late edge cannot complete a byte.
    always_comb begin
        shift_en = 1'b0;
        abort    = 1'b0;
        if (state_reg == ST_SHIFT) begin
            if (csn_s) begin
                abort = 1'b1;
            end else begin
                shift_en = rise;
            end
        end
    end

    // ---------------------------------------------------------------
    // Bit assembly
    // ---------------------------------------------------------------
    logic [2:0] bit_cnt_reg;
    logic [2:0] bit_cnt_next;
    logic [7:0] shift_reg;
    logic [7:0] shift_next;
    logic       byte_done;
    logic       frame_err_set;
    logic       push_reg;
    logic [8:0] push_data_reg;
    logic [8:0] push_data_next;

    always_comb begin
        bit_cnt_next = bit_cnt_reg;
        shift_next   = shift_reg;
        if (state_reg == ST_IDLE || abort) begin
            bit_cnt_next = '0;
            shift_next   = '0;
        end else if (shift_en) begin
            shift_next   = {shift_reg[6:0], mosi_s};
            bit_cnt_next = bit_cnt_reg + 3'd1;
        end
    end

    assign byte_done      = shift_en & (bit_cnt_reg == 3'd7);
    assign frame_err_set  = abort & (bit_cnt_reg != 3'd0);
    assign push_data_next = byte_done ? {dc_s, shift_next} : push_data_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_reg   <= '0;
            shift_reg     <= '0;
            push_reg      <= 1'b0;
            push_data_reg <= '0;
        end else begin
            bit_cnt_reg   <= bit_cnt_next;
            shift_reg     <= shift_next;
            push_reg      <= byte_done;
            push_data_reg <= push_data_next;
        end
    end

    // ---------------------------------------------------------------
    // Output FIFO with registered head
    // ---------------------------------------------------------------
    logic [8:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] wr_ptr_next;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;
    logic [CW-1:0] count_after_pop;
    logic [8:0]    head_reg;
    logic [8:0]    head_next;
    logic          valid_reg;
    logic          pop;
    logic          full;
    logic          wr_en;
    logic          overflow_set;

    assign pop             = valid_reg & rx.rx_ready;
    assign full            = (count_reg == FULL_CNT);
    assign wr_en           = push_reg & (~full | pop);
    assign overflow_set    = push_reg & full & ~pop;
    assign count_after_pop = count_reg - CW'(pop);
    assign count_next      = count_after_pop + CW'(wr_en);
    assign rd_ptr_next     = rd_ptr_reg + AW'(pop);
    assign wr_ptr_next     = wr_ptr_reg + AW'(wr_en);

    // When the FIFO drains to just the incoming entry, forward it straight to the head.
    always_comb begin
        head_next = head_reg;
        if (count_next != '0) begin
            if (count_after_pop == '0) begin
                head_next = push_data_reg;
            end else begin
                head_next = mem[rd_ptr_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= push_data_reg;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
            valid_reg  <= 1'b0;
        end else begin
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            head_reg   <= head_next;
            valid_reg  <= (count_next != '0);
        end
    end

    assign rx.rx_data  = head_reg[7:0];
    assign rx.rx_dc    = head_reg[8];
    assign rx.rx_valid = valid_reg;

    // ---------------------------------------------------------------
    // Sticky error flags: a set event beats a coincident clear
    // ---------------------------------------------------------------
    logic overflow_reg;
    logic frame_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            overflow_reg  <= overflow_set  | (overflow_reg  & ~clr_err);
            frame_err_reg <= frame_err_set | (frame_err_reg & ~clr_err);
        end
    end

    assign overflow  = overflow_reg;
    assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_spi_rx.sv
// Self-checking bench for spi_rx: drives SPI mode-0 frames, predicts FIFO output
// in a scoreboard queue and compares every popped byte.
module tb_spi_rx;

    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int HALF  = 4;   // spi_clk = clk/8

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic spi_clk = 1'b0;
    logic mosi    = 1'b0;
    logic cs_n    = 1'b1;
    logic dc      = 1'b0;
    logic clr_err = 1'b0;
    logic overflow;
    logic frame_err;
    logic busy;

    spi_rx_if rx_bus ();

    spi_rx #(
        .FIFO_DEPTH (DEPTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_clk  (spi_clk),
        .mosi     (mosi),
        .cs_n     (cs_n),
        .dc       (dc),
        .rx       (rx_bus),
        .overflow (overflow),
        .frame_err(frame_err),
        .clr_err  (clr_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int         tests_run    = 0;
    int         tests_failed = 0;
    int         valid_cycles = 0;
    logic [8:0] exp_q[$];
    logic [8:0] exp_pop;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: a pop happens at the next posedge whenever valid & ready.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_bus.rx_valid) valid_cycles++;
            if (rx_bus.rx_valid && rx_bus.rx_ready) begin
                exp_pop = 9'h1FF;
                if (exp_q.size() != 0) exp_pop = exp_q.pop_front();
                $display("[TB] pop dc=%0d data=0x%02h", rx_bus.rx_dc, rx_bus.rx_data);
                check_val("pop_byte", 32'({rx_bus.rx_dc, rx_bus.rx_data}), 32'(exp_pop));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            mosi = b[i];
            tick(HALF);
            spi_clk = 1'b1;
            tick(HALF);
            spi_clk = 1'b0;
        end
    endtask

    // mode 0: plain; 1: pulse rx_ready on the push cycle; 2: measure pin-to-valid latency
    task automatic send_byte(input logic [7:0] b, input logic d, input int mode);
        int   lat;
        logic dropped;
        lat = 0;
        for (int i = 7; i >= 0; i--) begin
            mosi = b[i];
            if (i == 7) dc = d;
            tick(HALF);
            spi_clk = 1'b1;
            if (i == 0) begin
                dropped = (exp_q.size() >= DEPTH) && (mode != 1);
                if (!dropped) exp_q.push_back({d, b});
                $display("[TB] send dc=%0d data=0x%02h%s", d, b, dropped ? " (dropped)" : "");
            end
            for (int k = 1; k <= HALF; k++) begin
                @(posedge clk);
                #1;
                if (i == 0 && mode == 1 && k == SYNC + 1) rx_bus.rx_ready = 1'b1;
                if (i == 0 && mode == 1 && k == SYNC + 2) rx_bus.rx_ready = 1'b0;
                if (i == 0 && mode == 2 && lat == 0 && rx_bus.rx_valid) lat = k;
            end
            spi_clk = 1'b0;
        end
        if (mode == 2) check_val("latency", 32'(lat), 32'(SYNC + 2));
    endtask

    task automatic frame_start();
        cs_n = 1'b0;
        tick(HALF);
    endtask

    task automatic frame_end();
        tick(HALF);
        cs_n = 1'b1;
        tick(SYNC + 2);
    endtask

    task automatic drain();
        rx_bus.rx_ready = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick(1);
            if (exp_q.size() == 0 && !rx_bus.rx_valid) break;
        end
        rx_bus.rx_ready = 1'b0;
        check_val("drain_queue", 32'(exp_q.size()), 32'd0);
        check_val("drain_valid", 32'(rx_bus.rx_valid), 32'd0);
    endtask

    task automatic check_idle_outputs(input string tag);
        check_val({tag, "_valid"}, 32'(rx_bus.rx_valid), 32'd0);
        check_val({tag, "_data"}, 32'(rx_bus.rx_data), 32'd0);
        check_val({tag, "_dc"}, 32'(rx_bus.rx_dc), 32'd0);
        check_val({tag, "_ovf"}, 32'(overflow), 32'd0);
        check_val({tag, "_ferr"}, 32'(frame_err), 32'd0);
        check_val({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rx_bus.rx_ready = 1'b0;
        tick(3);
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick(2);

        // Reset in the middle of a byte
        frame_start();
        send_bits(8'hB8, 5);
        check_val("busy_in_frame", 32'(busy), 32'd1);
        #3 rst_n = 1'b0;
        cs_n = 1'b1;
        #1 check_idle_outputs("midreset");
        tick(2);
        rst_n = 1'b1;
        tick(SYNC + 2);
        frame_start();
        send_byte(8'h3C, 1'b0, 0);
        frame_end();
        check_val("after_reset_ferr", 32'(frame_err), 32'd0);
        drain();

        // Single byte with consumer always ready
        rx_bus.rx_ready = 1'b1;
        valid_cycles = 0;
        frame_start();
        send_byte(8'hA5, 1'b0, 2);
        frame_end();
        check_val("single_valid_cycles", 32'(valid_cycles), 32'd1);
        check_val("single_ovf", 32'(overflow), 32'd0);
        check_val("single_ferr", 32'(frame_err), 32'd0);
        rx_bus.rx_ready = 1'b0;

        // Back-to-back bytes with different dc
        frame_start();
        send_byte(8'h81, 1'b0, 0);
        send_byte(8'h7E, 1'b1, 0);
        tick(4);
        check_val("b2b_valid", 32'(rx_bus.rx_valid), 32'd1);
        check_val("b2b_head", 32'({rx_bus.rx_dc, rx_bus.rx_data}), 32'h081);
        frame_end();
        check_val("b2b_ferr", 32'(frame_err), 32'd0);
        drain();

        // Overflow: five bytes into a four-entry FIFO
        frame_start();
        for (int v = 1; v <= 5; v++) send_byte(8'(v), 1'b0, 0);
        frame_end();
        check_val("ovf_set", 32'(overflow), 32'd1);
        check_val("ovf_head", 32'({rx_bus.rx_dc, rx_bus.rx_data}), 32'h001);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check_val("ovf_clear", 32'(overflow), 32'd0);

        // Push into a full FIFO with a simultaneous pop
        frame_start();
        send_byte(8'h55, 1'b0, 1);
        frame_end();
        check_val("fullpop_ovf", 32'(overflow), 32'd0);
        drain();

        // Frame aborted after three bits
        frame_start();
        send_bits(8'hA0, 3);
        tick(HALF);
        cs_n = 1'b1;
        tick(SYNC + 2);
        check_val("abort_ferr", 32'(frame_err), 32'd1);
        check_val("abort_valid", 32'(rx_bus.rx_valid), 32'd0);
        check_val("abort_busy", 32'(busy), 32'd0);
        clr_err = 1'b1;
        tick(1);
        clr_err = 1'b0;
        check_val("abort_clear", 32'(frame_err), 32'd0);
        frame_start();
        send_byte(8'hC3, 1'b1, 0);
        frame_end();
        check_val("abort_next_ferr", 32'(frame_err), 32'd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
